// File: rtl/pfa_pkg.sv
// Shared types and helpers for the pipelined-adder arbiter and its adder.
// Tag ids are sized for the largest supported requester count (8).
package pfa_pkg;

    localparam int ADDW    = 4;
    localparam int DEF_LAT = 2;
    localparam int IDW     = 3;

    typedef struct packed {
        logic            vld;
        logic [IDW-1:0]  id;
    } tag_t;

    // Priority moves to the requester just after the one that was served.
    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] idx, input int nreq);
        if (int'(idx) >= nreq - 1)
            return '0;
        else
            return idx + IDW'(1);
    endfunction

endpackage

// File: rtl/pfa_adder.sv
// Shared 4-bit ripple adder, result registered LAT edges after operand capture.
// Free-running pipeline; no stall, cleared by rst.
module pfa_adder
    import pfa_pkg::*;
#(
    parameter int LAT = DEF_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ADDW-1:0] a,
    input  logic [ADDW-1:0] b,
    input  logic            cin,
    output logic [ADDW-1:0] sum,
    output logic [ADDW-1:0] carry
);

    logic [ADDW-1:0]   s_c;
    logic [ADDW-1:0]   c_c;
    logic              c_in_bit;
    logic [2*ADDW-1:0] pipe [LAT];

    always_comb begin
        s_c      = '0;
        c_c      = '0;
        c_in_bit = cin;
        for (int i = 0; i < ADDW; i++) begin
            s_c[i]   = a[i] ^ b[i] ^ c_in_bit;
            c_c[i]   = (a[i] & b[i]) | (a[i] & c_in_bit) | (b[i] & c_in_bit);
            c_in_bit = c_c[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= {c_c, s_c};
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign sum   = pipe[LAT-1][ADDW-1:0];
    assign carry = pipe[LAT-1][2*ADDW-1:ADDW];

endmodule

// File: rtl/pfa_rr_grant.sv
// Round-robin priority select: first valid requester at or after ptr.
// Purely combinational; the caller gates the grant with its own enable.
module rr_grant
    import pfa_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [PW-1:0]   ptr,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            found
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!found && valid[pos]) begin
                grant[pos] = 1'b1;
                idx        = PW'(pos);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pfa_arbiter.sv
// Round-robin front end sharing one pipelined adder; results steered back by tag.
// Grant is same-cycle; response LAT cycles later with no backpressure.
module pfa_arbiter
    import pfa_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = DEF_LAT,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [ADDW*NREQ-1:0] req_a,
    input  logic [ADDW*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic [NREQ-1:0]      req_ready,
    output logic [ADDW-1:0]      add_a,
    output logic [ADDW-1:0]      add_b,
    output logic                 add_cin,
    input  logic [ADDW-1:0]      add_sum,
    input  logic [ADDW-1:0]      add_carry,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [ADDW-1:0]      rsp_sum,
    output logic                 rsp_cout,
    output logic [CNTW-1:0]      issue_cnt,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic [NREQ-1:0] grant;
    logic            found;
    logic            xfer;
    tag_t            stg [LAT];
    tag_t            last;
    logic            unused_carry;

    rr_grant #(.NREQ(NREQ), .PW(PW)) u_grant (
        .ptr   (ptr),
        .valid (req_valid),
        .grant (grant),
        .idx   (gidx),
        .found (found)
    );

    // The grant only ever lands on a valid requester, so ready implies transfer.
    assign req_ready = en ? grant : '0;
    assign xfer      = en & found;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (xfer) begin
            add_a   = req_a[int'(gidx)*ADDW +: ADDW];
            add_b   = req_b[int'(gidx)*ADDW +: ADDW];
            add_cin = req_cin[gidx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            issue_cnt <= '0;
            for (int k = 0; k < LAT; k++) stg[k] <= '0;
        end else begin
            if (xfer) begin
                ptr       <= PW'(rr_next(IDW'(gidx), NREQ));
                issue_cnt <= issue_cnt + CNTW'(1);
            end
            stg[0].vld <= xfer;
            stg[0].id  <= IDW'(gidx);
            for (int k = 1; k < LAT; k++) stg[k] <= stg[k-1];
        end
    end

    assign last = stg[LAT-1];

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < LAT; k++) busy = busy | stg[k].vld;
    end

    always_comb begin
        rsp_valid = '0;
        rsp_sum   = '0;
        rsp_cout  = 1'b0;
        if (last.vld) begin
            for (int i = 0; i < NREQ; i++)
                if (int'(last.id) == i) rsp_valid[i] = 1'b1;
            rsp_sum  = add_sum;
            rsp_cout = add_carry[ADDW-1];
        end
    end

    // Only the final carry leaves this block; the lower carries are intermediate.
    assign unused_carry = ^add_carry[ADDW-2:0];

endmodule

// File: tb/tb_pfa_arbiter.sv
// Bench for pfa_arbiter plus the shared adder: scoreboard of expected responses
// filled by the stimulus process and drained by an independent monitor.
module tb_pfa_arbiter;
    import pfa_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int CNTW = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [ADDW*NREQ-1:0] req_a = '0;
    logic [ADDW*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]      req_cin = '0;
    logic [NREQ-1:0]      req_ready;
    logic [ADDW-1:0]      add_a, add_b, add_sum, add_carry;
    logic                 add_cin;
    logic [NREQ-1:0]      rsp_valid;
    logic [ADDW-1:0]      rsp_sum;
    logic                 rsp_cout;
    logic [CNTW-1:0]      issue_cnt;
    logic                 busy;

    pfa_arbiter #(.NREQ(NREQ), .LAT(LAT), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_carry(add_carry),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .issue_cnt(issue_cnt), .busy(busy)
    );

    pfa_adder #(.LAT(LAT)) u_add (
        .clk(clk), .rst(rst), .a(add_a), .b(add_b), .cin(add_cin),
        .sum(add_sum), .carry(add_carry)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int sum;
        int cout;
        int due;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   mptr  = 0;
    int   mcnt  = 0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One cycle of stimulus; the model decides the grant from the round-robin rule.
    task automatic step(input logic [NREQ-1:0] v, input logic [ADDW*NREQ-1:0] a,
                        input logic [ADDW*NREQ-1:0] b, input logic [NREQ-1:0] c,
                        input logic e);
        int g, j, ai, bi, ci, s;
        @(negedge clk);
        req_valid = v; req_a = a; req_b = b; req_cin = c; en = e;
        #1;
        g = -1;
        if (e) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (mptr + k) % NREQ;
                if (g < 0 && v[j]) g = j;
            end
        end
        chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
        if (g >= 0) begin
            ai = int'(a >> (4 * g)) & 15;
            bi = int'(b >> (4 * g)) & 15;
            ci = int'(c[g]);
            s  = ai + bi + ci;
            chk("add_ops", int'({add_a, add_b, add_cin}), (ai << 5) | (bi << 1) | ci);
            q.push_back('{g, s & 15, s >> 4, cyc + LAT});
            mptr = (g + 1) % NREQ;
            mcnt = (mcnt + 1) % (1 << CNTW);
        end else begin
            chk("add_idle", int'({add_a, add_b, add_cin}), 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        en = 1'b0;
        #1;
        rst = 1'b1;
        q.delete();
        mptr = 0;
        mcnt = 0;
        #1;
        chk("busy_async_rst", int'(busy), 0);
        chk("cnt_async_rst", int'(issue_cnt), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: independent of the driver, runs every cycle at the falling edge.
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", int'(busy), (q.size() > 0) ? 1 : 0);
            chk("issue_cnt", int'(issue_cnt), mcnt);
            if (rsp_valid != '0) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", int'(rsp_valid), 0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_valid", int'(rsp_valid), 1 << e.id);
                    chk("rsp_sum", int'(rsp_sum), e.sum);
                    chk("rsp_cout", int'(rsp_cout), e.cout);
                    chk("rsp_cycle", cyc, e.due);
                end
            end else begin
                chk("rsp_idle", int'({rsp_sum, rsp_cout}), 0);
                if (q.size() > 0 && q[0].due <= cyc) begin
                    e = q.pop_front();
                    chk("rsp_missing", int'(rsp_valid), 1 << e.id);
                end
            end
        end
    end

    logic [ADDW*NREQ-1:0] ra, rb;
    logic [NREQ-1:0]      rv, rc;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        // Single op 7+9: sum 0 with carry out.
        step(4'b0001, 16'h0007, 16'h0009, 4'b0000, 1'b1);
        idle(3);

        // All requesters valid, distinct operands each cycle.
        for (int i = 0; i < 12; i++) begin
            ra = {4'h4, 4'h3, 4'h2, 4'h1} + 16'(i * 16'h1111);
            rb = 16'(16'hF0A5 ^ (i * 16'h0123));
            step(4'b1111, ra, rb, 4'(i), 1'b1);
        end
        idle(3);

        // Requester 2 back-to-back: 3+4+1 then F+F+1.
        step(4'b0100, 16'h0300, 16'h0400, 4'b0100, 1'b1);
        step(4'b0100, 16'h0F00, 16'h0F00, 4'b0100, 1'b1);
        idle(3);

        // Enable low blocks grants; dropping it mid-stream still drains.
        for (int i = 0; i < 3; i++) step(4'b1111, 16'h1234, 16'h5678, 4'b1010, 1'b0);
        step(4'b1111, 16'h9ABC, 16'hDEF0, 4'b0101, 1'b1);
        step(4'b1111, 16'h9ABC, 16'hDEF0, 4'b0101, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b1111, 16'h1111, 16'h2222, 4'b1111, 1'b0);

        // Reset with two ops in flight; first grant afterwards is requester 0.
        step(4'b1111, 16'h8888, 16'h7777, 4'b0000, 1'b1);
        step(4'b1111, 16'h8888, 16'h7777, 4'b0000, 1'b1);
        do_reset();
        idle(2);
        step(4'b1111, 16'h4321, 16'h1234, 4'b0001, 1'b1);
        idle(3);

        // Randomized traffic; issue_cnt wraps repeatedly with CNTW=4.
        for (int i = 0; i < 600; i++) begin
            rv = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3))
                                              : 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 4'($urandom);
            step(rv, ra, rb, rc, ($urandom_range(0, 9) != 0));
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
        idle(1);
        chk("drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
